// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle for sync_fifo: write/read strobes, status flags
// and data buses. The FIFO sits on the slave side.
interface sync_fifo_if #(
  parameter int d_w = 8
) ();

  logic           write;
  logic           read;
  logic           full;
  logic           empty;
  logic [d_w-1:0] data_in;
  logic [d_w-1:0] data_out;

  // Producer/consumer side: issues strobes and write data, observes status.
  modport master (
    output write,
    output read,
    output data_in,
    input  full,
    input  empty,
    input  data_out
  );

  // FIFO side: accepts strobes and write data, reports status and read data.
  modport slave (
    input  write,
    input  read,
    input  data_in,
    output full,
    output empty,
    output data_out
  );

endinterface : sync_fifo_if

// File: rtl/sync_fifo.sv
// Single-clock FIFO of 2**ad_w words of d_w bits with a registered read port.
// Pointers carry one extra wrap bit so that full and empty can be told apart
// when the index bits match. A read on an empty FIFO and a write on a full
// FIFO are both silently ignored. There is no fall-through path: a word
// written into an empty FIFO reaches data_out only through a later read.
module sync_fifo #(
  parameter int d_w  = 8,
  parameter int ad_w = 4
) (
  input  logic       clk,
  input  logic       rst,
  sync_fifo_if.slave bus
);

  localparam int depth = 2 ** ad_w;

  logic [d_w-1:0] mem [depth];
  logic [ad_w:0]  wr_ptr;
  logic [ad_w:0]  rd_ptr;
  logic [d_w-1:0] rd_data;

  logic           empty_int;
  logic           full_int;
  logic           wr_accept;
  logic           rd_accept;

  // Status flags and accept decisions, all taken from the registered pointers.
  // NOTE: every always_comb output is assigned a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    empty_int = 1'b0;
    full_int  = 1'b0;
    wr_accept = 1'b0;
    rd_accept = 1'b0;

    empty_int = (wr_ptr == rd_ptr);
    full_int  = (wr_ptr[ad_w-1:0] == rd_ptr[ad_w-1:0]) &&
                (wr_ptr[ad_w] != rd_ptr[ad_w]);

    wr_accept = bus.write && !full_int;
    rd_accept = bus.read  && !empty_int;
  end

  // Pointer and read-data registers; reset takes priority over both strobes.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_data <= mem[rd_ptr[ad_w-1:0]];
        rd_ptr  <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage array write port; read and write never target the same live
  // entry in one edge because that would need the FIFO both full and empty.
  // NOTE: the array is deliberately left out of reset. Resetting the pointers
  // already discards every stored word, and leaving the array unreset lets it
  // map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wr_ptr[ad_w-1:0]] <= bus.data_in;
    end
  end

  assign bus.empty    = empty_int;
  assign bus.full     = full_int;
  assign bus.data_out = rd_data;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed steps followed by a random
// phase, compared each cycle against a queue-based model of the FIFO.
module tb_sync_fifo;

  localparam int d_w   = 8;
  localparam int ad_w  = 4;
  localparam int depth = 2 ** ad_w;

  logic clk;
  logic rst;

  sync_fifo_if #(.d_w(d_w)) bus ();

  sync_fifo #(.d_w(d_w), .ad_w(ad_w)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue holding the words in FIFO order, plus the
  // value data_out is expected to show.
  logic [d_w-1:0] model_q [$];
  logic [d_w-1:0] exp_dout;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, advance the model by the FIFO rules, and
  // compare all outputs shortly after the edge.
  task automatic cycle(input string tag, input logic rs, input logic rd,
                       input logic wr, input logic [d_w-1:0] din);
    bit do_rd;
    bit do_wr;
    rst          = rs;
    bus.read     = rd;
    bus.write    = wr;
    bus.data_in  = din;
    @(posedge clk);
    if (rs) begin
      model_q.delete();
      exp_dout = '0;
    end else begin
      do_rd = rd && (model_q.size() != 0);
      do_wr = wr && (model_q.size() != depth);
      if (do_rd) exp_dout = model_q.pop_front();
      if (do_wr) model_q.push_back(din);
    end
    #1;
    check({tag, ".empty"}, 32'(bus.empty), 32'(model_q.size() == 0));
    check({tag, ".full"},  32'(bus.full),  32'(model_q.size() == depth));
    check({tag, ".dout"},  32'(bus.data_out), 32'(exp_dout));
    check({tag, ".excl"},  32'(bus.full && bus.empty), 32'(0));
  endtask

  initial begin
    rst         = 1'b1;
    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.data_in = '0;
    exp_dout    = '0;

    // Reset state, then a read on the empty FIFO must leave data_out at 0.
    cycle("reset", 1'b1, 1'b0, 1'b0, 8'h00);
    check("reset.empty_abs", 32'(bus.empty), 32'(1));
    check("reset.dout_abs", 32'(bus.data_out), 32'(0));
    cycle("rd_empty", 1'b0, 1'b1, 1'b0, 8'h00);
    check("rd_empty.dout_abs", 32'(bus.data_out), 32'(0));

    // Fill with 1..16, then a 17th write that must be dropped.
    for (int i = 1; i <= depth; i++) cycle("fill", 1'b0, 1'b0, 1'b1, 8'(i));
    check("fill.full_abs", 32'(bus.full), 32'(1));
    cycle("overflow", 1'b0, 1'b0, 1'b1, 8'd17);
    check("overflow.full_abs", 32'(bus.full), 32'(1));

    // Drain: 1..16 in order, then extra reads hold data_out at 16.
    for (int i = 1; i <= depth; i++) begin
      cycle("drain", 1'b0, 1'b1, 1'b0, 8'h00);
      check("drain.seq", 32'(bus.data_out), 32'(i));
    end
    check("drain.empty_abs", 32'(bus.empty), 32'(1));
    cycle("underflow", 1'b0, 1'b1, 1'b0, 8'h00);
    cycle("underflow", 1'b0, 1'b1, 1'b0, 8'h00);
    check("underflow.dout_abs", 32'(bus.data_out), 32'(16));

    // Refill, then alternate read/write for 6 cycles starting from full.
    for (int i = 0; i < depth; i++) cycle("refill", 1'b0, 1'b0, 1'b1, 8'(8'h40 + i));
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) cycle("alt", 1'b0, 1'b1, 1'b0, 8'h00);
      else            cycle("alt", 1'b0, 1'b0, 1'b1, 8'(8'h80 + i));
    end

    // Full with both strobes: only the read goes through.
    cycle("rw_full", 1'b0, 1'b1, 1'b1, 8'hEE);

    // Drain down to 5 words, then 10 cycles of simultaneous read+write.
    while (model_q.size() > 5) cycle("to5", 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cycle("rw5", 1'b0, 1'b1, 1'b1, 8'(8'hC0 + i));
      check("rw5.occ", 32'(model_q.size()), 32'(5));
    end

    // Empty with both strobes: write only, no fall-through.
    while (model_q.size() > 0) cycle("to0", 1'b0, 1'b1, 1'b0, 8'h00);
    cycle("rw_empty", 1'b0, 1'b1, 1'b1, 8'h5A);
    check("rw_empty.empty_abs", 32'(bus.empty), 32'(0));
    check("rw_empty.dout_abs", 32'(bus.data_out), 32'(8'hC9));
    cycle("rw_empty_rd", 1'b0, 1'b1, 1'b0, 8'h00);
    check("rw_empty_rd.dout_abs", 32'(bus.data_out), 32'(8'h5A));

    // Mid-operation reset discards stored words; strobes are X during reset.
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b0, 1'b0, 1'b1, 8'(8'h10 + i));
    cycle("mid_rst", 1'b1, 1'bx, 1'bx, 8'hxx);
    check("mid_rst.empty_abs", 32'(bus.empty), 32'(1));
    cycle("post_rst_wr", 1'b0, 1'b0, 1'b1, 8'hAA);
    cycle("post_rst_rd", 1'b0, 1'b1, 1'b0, 8'h00);
    check("post_rst.dout_abs", 32'(bus.data_out), 32'(8'hAA));
    check("post_rst.empty_abs", 32'(bus.empty), 32'(1));

    // Random phase with a write bias early on and occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic rs;
      logic rd;
      logic wr;
      rs = ($urandom_range(0, 79) == 0);
      rd = ($urandom_range(0, 99) < (i < 300 ? 35 : 65));
      wr = ($urandom_range(0, 99) < (i < 300 ? 65 : 35));
      cycle("rand", rs, rd, wr, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the directed and random phases finish well inside this bound.
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_sync_fifo
